// File: rtl/aes_key_schedule.sv
// AES key-expansion engine: one 32-bit schedule word per clock, grouped into
// 128-bit round keys streamed over a valid/ready handshake.
// NK selects AES-128/192/256 (4/6/8). Optional macro KS_REVERSE_EN adds a
// rev input and a round-key store so keys can be streamed NR..0.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = SBOX[a];
endmodule

module aes_key_schedule #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key_in,
`ifdef KS_REVERSE_EN
  input  logic         rev,
`endif
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         done
);
  localparam int NR   = NK + 6;
  localparam int LAST = 4*NR + 3;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $fatal(1, "aes_key_schedule: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [5:0]           idx;    // index of the word generated next
  logic [2:0]           kpos;   // idx % NK
  logic [7:0]           rcon;
  logic [NK-1:0][31:0]  win;    // win[0] = w[idx-NK], win[NK-1] = w[idx-1]
  logic [2:0][31:0]     asm_q;  // assembler slots 0..2; slot 3 goes straight out
  logic [31:0]          t, sb_in, sub, w_new;
  logic                 rev_q, accept, hs, slot3, stall, adv, last_word, more_rev;
  logic                 unused_key;

  assign unused_key = ^key_in;

`ifdef KS_REVERSE_EN
  logic [127:0] store [0:NR];
  // capture every completed round key for the reverse stream
  always_ff @(posedge clk)
    if (adv && slot3) store[idx[5:2]] <= {asm_q[0], asm_q[1], asm_q[2], w_new};
`else
  assign rev_q = 1'b0;
`endif

  assign accept    = (state == IDLE) && start && !done;
  assign hs        = rk_valid && rk_ready;
  assign slot3     = (idx[1:0] == 2'd3);
  assign stall     = slot3 && rk_valid && !rk_ready;
  assign adv       = (state == RUN) && !stall;
  assign last_word = (idx == 6'(LAST));
  assign more_rev  = rev_q && (rk_round != 4'd0);
  assign busy      = (state != IDLE);
  assign rk_last   = rk_valid && (rk_round == (rev_q ? 4'd0 : 4'(NR)));

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[8*b +: 8]), .y(sub[8*b +: 8]));
  end

  // next schedule word from the sliding window
  always_comb begin
    t     = win[NK-1];
    sb_in = (kpos == 3'd0) ? {t[23:0], t[31:24]} : t;
    w_new = win[0];
    if (idx >= 6'(NK)) begin
      if (kpos == 3'd0)                 w_new = win[0] ^ sub ^ {rcon, 24'h0};
      else if (NK == 8 && kpos == 3'd4) w_new = win[0] ^ sub;
      else                              w_new = win[0] ^ t;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (adv && last_word) state_nxt = DRAIN;
      DRAIN:   if (hs && !more_rev) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // word generation, assembly and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      kpos     <= '0;
      rcon     <= '0;
      win      <= '0;
      asm_q    <= '0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_round <= '0;
      done     <= 1'b0;
`ifdef KS_REVERSE_EN
      rev_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (hs) rk_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          for (int j = 0; j < NK; j++) win[j] <= key_in[255-32*j -: 32];
          idx  <= '0;
          kpos <= '0;
          rcon <= 8'h01;
`ifdef KS_REVERSE_EN
          rev_q <= rev;
`endif
        end
        RUN: if (adv) begin
          win  <= {w_new, win[NK-1:1]};
          idx  <= idx + 6'd1;
          kpos <= (kpos == 3'(NK-1)) ? 3'd0 : kpos + 3'd1;
          if (idx >= 6'(NK) && kpos == 3'd0)
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          case (idx[1:0])
            2'd0: asm_q[0] <= w_new;
            2'd1: asm_q[1] <= w_new;
            2'd2: asm_q[2] <= w_new;
            default: if (!rev_q || last_word) begin
              rk_data  <= {asm_q[0], asm_q[1], asm_q[2], w_new};
              rk_round <= idx[5:2];
              rk_valid <= 1'b1;
            end
          endcase
        end
        DRAIN: if (hs) begin
`ifdef KS_REVERSE_EN
          if (more_rev) begin
            rk_data  <= store[rk_round - 4'd1];
            rk_round <= rk_round - 4'd1;
            rk_valid <= 1'b1;
          end else
`endif
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench: one DUT per key size, FIPS-197 vector table plus
// random keys/backpressure checked against a textbook key-expansion model.
module tb_aes_key_schedule;
  logic clk = 1'b0, reset_n = 1'b0, rk_ready = 1'b1;
  logic [255:0] key_in = '0;
  logic [2:0] start_v = '0, busy_v, vld_v, last_v, done_v;
  logic [2:0][127:0] data_v;
  logic [2:0][3:0] round_v;
`ifdef KS_REVERSE_EN
  logic rev = 1'b0;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_key_schedule #(.NK(4 + 2*g)) dut (
      .clk(clk), .reset_n(reset_n), .start(start_v[g]), .key_in(key_in),
`ifdef KS_REVERSE_EN
      .rev(rev),
`endif
      .busy(busy_v[g]), .rk_valid(vld_v[g]), .rk_ready(rk_ready),
      .rk_data(data_v[g]), .rk_round(round_v[g]), .rk_last(last_v[g]), .done(done_v[g]));
  end

  int nerr = 0, nchk = 0, nkeys;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [15];
  logic [127:0] got_data [16];
  int           got_round [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_t[v[31:24]], sbox_t[v[23:16]], sbox_t[v[15:8]], sbox_t[v[7:0]]};
  endfunction

  // FIPS-197 key expansion, fills exp_rk[0..NR]
  task automatic model(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk + 6; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // one expansion on DUT sel; pct = rk_ready duty in percent
  task automatic run(input int sel, input logic [255:0] key, input int pct, input bit rv,
                     input int abort_after, input bit poke);
    int nr = 4 + 2*sel + 6;
    int first = -1;
    bit held = 0, fin = 0, ab = 0, rdy;
    logic [127:0] hd;
    logic [3:0] hr;
    logic hl;
    model(4 + 2*sel, key);
    nkeys = 0;
    @(negedge clk);
    key_in = key;
`ifdef KS_REVERSE_EN
    rev = rv;
`endif
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    key_in = ~key;
    chk("busy_after_start", busy_v[sel], 1);
    for (int k = 0; k < 3000 && !fin && !ab; k++) begin
      if (held) begin
        chk("hold_data", data_v[sel], hd);
        chk("hold_round", round_v[sel], hr);
        chk("hold_last", last_v[sel], hl);
      end
      if (vld_v[sel] && first < 0) begin
        first = k;
        chk("first_key_latency", k, rv ? 4*(nr+1) : 4);
      end
      start_v[sel] = poke && (k == 7 || k == 22);
      rdy = ($urandom_range(99, 0) < pct);
      rk_ready = rdy;
      if (vld_v[sel]) begin
        chk("rk_last", last_v[sel], nkeys == nr);
        if (rdy) begin
          if (nkeys < 16) begin
            got_data[nkeys] = data_v[sel];
            got_round[nkeys] = int'(round_v[sel]);
          end
          if (nkeys == nr) fin = 1;
          nkeys++;
          if (nkeys == abort_after) ab = 1;
        end
      end
      held = vld_v[sel] && !rdy;
      hd = data_v[sel]; hr = round_v[sel]; hl = last_v[sel];
      @(negedge clk);
    end
    start_v[sel] = 1'b0;
    rk_ready = 1'b1;
    if (ab) begin
      reset_n = 1'b0;
      #1;
      chk("rst_busy", busy_v[sel], 0);
      chk("rst_valid", vld_v[sel], 0);
      chk("rst_data", data_v[sel], 0);
      chk("rst_round", round_v[sel], 0);
      chk("rst_last", last_v[sel], 0);
      chk("rst_done", done_v[sel], 0);
      @(negedge clk);
      reset_n = 1'b1;
      return;
    end
    if (!fin) begin
      chk("timeout_final_key", 0, 1);
      return;
    end
    chk("done_pulse", done_v[sel], 1);
    chk("busy_fall", busy_v[sel], 0);
    chk("valid_fall", vld_v[sel], 0);
    // start in the done cycle must be ignored
    key_in = key;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    chk("start_in_done_ignored", busy_v[sel], 0);
    chk("done_one_cycle", done_v[sel], 0);
    chk("key_count", nkeys, nr + 1);
    for (int i = 0; i <= nr && i < nkeys; i++) begin
      int er = rv ? nr - i : i;
      chk("seq_round", got_round[i], er);
      chk("seq_data", got_data[i], exp_rk[er]);
    end
  endtask

  typedef struct {
    int           sel;
    logic [255:0] key;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    vec_t tbl[5];
    logic [255:0] rk;
    tbl[0] = '{0, K128, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[1] = '{0, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[2] = '{0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[3] = '{1, K192, 12, 128'he98ba06f448c773c8ecc720401002202};
    tbl[4] = '{2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e};
    build_sbox();

    #12;
    for (int g = 0; g < 3; g++) begin
      chk("reset_busy", busy_v[g], 0);
      chk("reset_valid", vld_v[g], 0);
      chk("reset_data", data_v[g], 0);
      chk("reset_round", round_v[g], 0);
      chk("reset_last", last_v[g], 0);
      chk("reset_done", done_v[g], 0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // known-answer vectors, rk_ready held high
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].sel, tbl[i].key, 100, 0, -1, 0);
      chk("vector_round", got_round[tbl[i].rnd], tbl[i].rnd);
      chk("vector_data", got_data[tbl[i].rnd], tbl[i].exp);
    end

    // FIPS key under 30% backpressure
    run(0, K128, 30, 0, -1, 0);
    chk("bp_r10", got_data[10], tbl[2].exp);

    // random keys for every key size, mixed backpressure
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
      run(i % 3, rk, (i < 3) ? 30 : 70, 0, -1, 0);
    end

    // reset after r3 accepted, then restart from scratch
    run(0, K128, 100, 0, 4, 0);
    run(0, K128, 100, 0, -1, 0);

    // start pulses while busy are ignored
    run(0, K128, 50, 0, -1, 1);
    run(2, K256, 50, 0, -1, 1);

`ifdef KS_REVERSE_EN
    run(0, K128, 100, 1, -1, 0);
    chk("rev_first_data", got_data[0], tbl[2].exp);
    chk("rev_last_data", got_data[10], tbl[0].exp);
    for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
    run(1, rk, 30, 1, -1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
